// File: rtl/xalu_md.sv
// HI/LO multiply/divide unit: result computed at issue, committed to {hi,lo} after MULT_CYCLES/DIV_CYCLES.
// stall_req holds the pipeline while busy or while a long op is being issued; XALU_DIVZERO_KEEP_EN keeps hi/lo on divide-by-zero.
module xalu_md #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2   = 2 * WIDTH;
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [3:0] OP_MTLO  = 4'd1;
  localparam logic [3:0] OP_MTHI  = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MULT  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  logic [CW-1:0]    cnt;
  logic [W2-1:0]    pend;
  logic [W2-1:0]    pend_nxt;
  logic [W2-1:0]    ax, bx, prod;
  logic             long_op, is_div, prod_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] ua, ub, ub_safe, q, r, qs, rs;

  assign busy      = (cnt != '0);
  assign long_op   = (op >= OP_DIVU) && (op <= OP_MSUBU) && (op != 4'd7) && (op != 4'd8);
  assign is_div    = (op == OP_DIVU) || (op == OP_DIV);
  assign stall_req = busy | (start & (op >= OP_DIVU) & (op <= OP_MSUBU));

  always_comb begin
    prod_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    ax   = prod_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    bx   = prod_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod = ax * bx;

    // Signed divide runs on magnitudes; MIN_INT / -1 falls out as MIN_INT with zero remainder.
    a_neg   = (op == OP_DIV) & a[WIDTH-1];
    b_neg   = (op == OP_DIV) & b[WIDTH-1];
    ua      = a_neg ? (~a + ONE) : a;
    ub      = b_neg ? (~b + ONE) : b;
    ub_safe = (ub == '0) ? ONE : ub;
    q       = ua / ub_safe;
    r       = ua % ub_safe;
    qs      = (a_neg ^ b_neg) ? (~q + ONE) : q;
    rs      = a_neg ? (~r + ONE) : r;

    pend_nxt = {hi, lo};
    case (op)
      OP_DIVU, OP_DIV: begin
        if (b == '0) begin
`ifdef XALU_DIVZERO_KEEP_EN
          pend_nxt = {hi, lo};
`else
          pend_nxt = {a, {WIDTH{1'b1}}};
`endif
        end else begin
          pend_nxt = {rs, qs};
        end
      end
      OP_MULTU, OP_MULT: pend_nxt = prod;
      OP_MADD, OP_MADDU: pend_nxt = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: pend_nxt = {hi, lo} - prod;
      default:           pend_nxt = {hi, lo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      pend <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= pend[W2-1:WIDTH];
        lo <= pend[WIDTH-1:0];
      end
    end else if (start) begin
      if (op == OP_MTLO) begin
        lo <= a;
      end else if (op == OP_MTHI) begin
        hi <= a;
      end else if (long_op) begin
        pend <= pend_nxt;
        cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end
    end
  end

endmodule

// File: tb/tb_xalu_md.sv
// Directed bench for xalu_md: sequential vector table plus hand-written busy/reset corner sequences.
module tb_xalu_md;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  logic        start16;
  logic [3:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16, stall16;
  logic [15:0] hi16, lo16;

  int tests = 0;
  int fails = 0;

  xalu_md #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  xalu_md #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(2)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .stall_req(stall16), .hi(hi16), .lo(lo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    logic        stall;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    #1 chk({nm, ".stall"}, 64'(stall_req), 64'(v.stall));
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, ".busy_cycles"}, 64'(n), 64'(v.cyc));
    chk({nm, ".hi"}, 64'(hi), 64'(v.hi));
    chk({nm, ".lo"}, 64'(lo), 64'(v.lo));
  endtask

  initial begin
    int n;
    vt[0]  = '{4'd6,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  1'b1};
    vt[1]  = '{4'd5,  32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5,  1'b1};
    vt[2]  = '{4'd4,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b1};
    vt[3]  = '{4'd4,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b1};
    vt[4]  = '{4'd1,  32'h00000010, 32'd0,        32'h00000000, 32'h00000010, 0,  1'b0};
    vt[5]  = '{4'd2,  32'h00000000, 32'd0,        32'h00000000, 32'h00000010, 0,  1'b0};
    vt[6]  = '{4'd9,  32'd2,        32'd3,        32'h00000000, 32'h00000016, 5,  1'b1};
    vt[7]  = '{4'd12, 32'h00000016, 32'd1,        32'h00000000, 32'h00000000, 5,  1'b1};
    vt[8]  = '{4'd3,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10, 1'b1};
    vt[9]  = '{4'd11, 32'd3,        32'hFFFFFFFF, 32'h00000002, 32'h00000011, 5,  1'b1};
    vt[10] = '{4'd10, 32'hFFFFFFFF, 32'd2,        32'h00000004, 32'h0000000F, 5,  1'b1};
    vt[11] = '{4'd0,  32'd5,        32'd5,        32'h00000004, 32'h0000000F, 0,  1'b0};
    vt[12] = '{4'd13, 32'd5,        32'd5,        32'h00000004, 32'h0000000F, 0,  1'b0};
    vt[13] = '{4'd7,  32'd5,        32'd5,        32'h00000004, 32'h0000000F, 0,  1'b1};

    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    start16 = 1'b0; op16 = 4'd0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.stall", 64'(stall_req), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Requests arriving while a mult is in flight must be dropped.
    run_vec('{4'd1, 32'h00000023, 32'd0, 32'h00000004, 32'h00000023, 0, 1'b0}, "pre_lo");
    run_vec('{4'd2, 32'h00000000, 32'd0, 32'h00000000, 32'h00000023, 0, 1'b0}, "pre_hi");
    @(negedge clk);
    start = 1'b1; op = 4'd6; a = 32'd5; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    @(posedge clk); #1;
    start = 1'b1; op = 4'd2; a = 32'h1234;
    #1 chk("ign.stall", 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    op = 4'd4; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    n = 3;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign.busy_cycles", 64'(n), 64'd5);
    chk("ign.hi", 64'(hi), 64'd0);
    chk("ign.lo", 64'(lo), 64'h23);

`ifdef XALU_DIVZERO_KEEP_EN
    run_vec('{4'd4, 32'h00000055, 32'd0, 32'h00000000, 32'h00000023, 10, 1'b1}, "divz");
    run_vec('{4'd3, 32'h00000077, 32'd0, 32'h00000000, 32'h00000023, 10, 1'b1}, "divuz");
`else
    run_vec('{4'd4, 32'h00000055, 32'd0, 32'h00000055, 32'hFFFFFFFF, 10, 1'b1}, "divz");
    run_vec('{4'd3, 32'h00000077, 32'd0, 32'h00000077, 32'hFFFFFFFF, 10, 1'b1}, "divuz");
`endif

    // Narrow instance: single-cycle multiply.
    @(negedge clk);
    start16 = 1'b1; op16 = 4'd6; a16 = 16'hFFFF; b16 = 16'hFFFF;
    #1 chk("w16.stall", 64'(stall16), 64'd1);
    @(posedge clk); #1;
    start16 = 1'b0; op16 = 4'd0;
    n = 0;
    while (busy16 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w16.mult.busy_cycles", 64'(n), 64'd1);
    chk("w16.mult.hi", 64'(hi16), 64'd0);
    chk("w16.mult.lo", 64'(lo16), 64'd1);
    @(negedge clk);
    start16 = 1'b1; op16 = 4'd5;
    @(posedge clk); #1;
    start16 = 1'b0; op16 = 4'd0;
    @(posedge clk); #1;
    chk("w16.multu.hi", 64'(hi16), 64'hFFFE);
    chk("w16.multu.lo", 64'(lo16), 64'h0001);

    // Reset in busy cycle 3 of a divide discards the pending result.
    @(negedge clk);
    start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid.busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid.busy", 64'(busy), 64'd0);
    chk("rst_mid.hi", 64'(hi), 64'd0);
    chk("rst_mid.lo", 64'(lo), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("rst_mid.late_hi", 64'(hi), 64'd0);
    chk("rst_mid.late_lo", 64'(lo), 64'd0);
    chk("rst_mid.late_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
